lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer between the core's memory stage and the word-only data memory. The data memory has a 1024-word array, word index addr[11:2], write-enable-gated combinational read and synchronous write.
- Accepts one request at a time over a valid/ready handshake.
- Loads: extracts and sign- or zero-extends byte/half/word data.
- Sub-word stores: performs read-modify-write as two memory cycles.
- Returns a registered response with an optional misalignment error.

Parameters:
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, data width; only 32 supported

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept (IDLE only)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word
req_unsigned  input  1  zero-extend loads when 1
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_rdata  output  DATA_WIDTH  load result (0 for stores/errors)
rsp_err  output  1  misaligned access flag
mem_addr  output  ADDR_WIDTH  to data memory addr
mem_write_data  output  DATA_WIDTH  to data memory write_data
mem_write_enable  output  1  to data memory write_enable
mem_read_data  input  DATA_WIDTH  from data memory read_data

Behaviour:
- Reset, asynchronous: state=IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_write_enable=0, mem_addr=0, mem_write_data=0; all latched request fields cleared. Reset mid-operation drops mem_write_enable immediately and discards the request. A write already clocked in stays in memory.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/size/we/unsigned/wdata.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP with err=1; no memory access.
  - Load -> LOAD.
  - Word store -> WRITE with merge=wdata.
  - Byte/half store -> RMW_RD.
- LOAD: mem_addr={addr[31:2],2'b00}, we=0. Select lane(s) by addr[1:0], extend per size/unsigned, register into rsp_rdata. Go to RESP.
- RMW_RD: same address, we=0. Register merge word = mem_read_data with the addressed byte (or half at addr[1]) replaced by wdata[7:0] (or [15:0]). Go to WRITE.
- WRITE: mem_write_enable=1, mem_write_data=merge. Memory commits on the exiting edge. Go to RESP.
- RESP: rsp_valid=1 and stable until rsp_ready. On the handshake edge go to IDLE and clear rsp_valid/rsp_err. req_ready=0, so a new request is accepted no earlier than the next IDLE cycle.
- Latency, from accept edge to first rsp_valid cycle: misaligned 1, load 2, word store 2, sub-word store 3.
- mem_write_enable is high only in WRITE, so reads are never masked to 0 during LOAD/RMW_RD.
- Extension: byte -> {24{sign?b[7]:0},b}; half -> {16{sign?h[15]:0},h}.
- rsp_rdata is 0 for stores and errors.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misaligned accesses return rsp_err=1 as above, with no memory access.
- Undefined: no check. Half uses addr[1] only; word ignores addr[1:0]. rsp_err is tied 0 and the access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum logic [2:0] lsu_state_t {IDLE, LOAD, RMW_RD, WRITE, RESP};
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
- One combinational sub-module, lsu_lane, holds lane extract/extend and store merge functions. It is shared by the LOAD and RMW_RD paths.
- The FSM and registers stay in lsu_ctrl.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10.
  - Store: rsp_valid 2 cycles after accept.
  - Load: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Sub-word RMW: mem[0x20]=0x11223344; store byte 0xAA @0x21 -> mem[0x20]=0x1122AA44, rsp 3 cycles after accept. Store half 0xBEEF @0x22 -> 0xBEEFAA44.
- Load extension: word=0x80FF7F01.
  - lb @+2 -> 0xFFFFFFFF.
  - lbu @+2 -> 0x000000FF.
  - lh @+2 -> 0xFFFF80FF.
  - lb @+0 -> 0x00000001.
- Misalignment (macro on): lw @0x13 -> rsp_err=1, rdata=0, 1-cycle latency, mem_write_enable never high. Macro off: same access returns mem[0x10].
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - rsp_valid/rdata stay stable and req_ready=0 throughout.
  - A req_valid held high is accepted the cycle after the handshake.
- Reset: assert rst during RMW_RD of a byte store to 0x30.
  - Outputs go to reset values immediately.
  - mem[0x30] is unchanged.
  - The next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store sequencer.
//   lsu_state_t   - controller FSM states
//   SIZE_*        - encodings of the req_size field (2'b11 behaves as word)
//   is_misaligned - alignment test used when LSU_MISALIGN_CHECK_EN is defined
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Bytes are always aligned; halves need addr[0]=0; words (and size 11) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return byte_off[0];
            default:   return byte_off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic shared by the load and read-modify-write paths.
// Ports:
//   rd_word      in  32  word read from data memory
//   byte_off     in  2   byte offset within the word (addr[1:0])
//   size         in  2   access size (SIZE_BYTE / SIZE_HALF / word)
//   is_unsigned  in  1   zero-extend loads when 1
//   wdata        in  32  right-aligned store data
//   load_data    out 32  selected lane(s), sign/zero extended
//   merge_data   out 32  rd_word with the addressed lane(s) replaced by wdata
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    function automatic logic [31:0] extract_extend(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] ext;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        // Halves are selected by addr[1] alone; addr[0] is either rejected or ignored upstream.
        h  = off[1] ? w[31:16] : w[15:0];
        sb = b;
        sh = h;
        case (sz)
            SIZE_BYTE: begin
                ext = sb;
                return uns ? {24'd0, b} : ext;
            end
            SIZE_HALF: begin
                ext = sh;
                return uns ? {16'd0, h} : ext;
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic [31:0] wd
    );
        logic [31:0] m;
        m = w;
        case (sz)
            SIZE_BYTE: begin
                case (off)
                    2'd0:    m[7:0]   = wd[7:0];
                    2'd1:    m[15:8]  = wd[7:0];
                    2'd2:    m[23:16] = wd[7:0];
                    default: m[31:24] = wd[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (off[1]) m[31:16] = wd[15:0];
                else        m[15:0]  = wd[15:0];
            end
            default: m = wd;
        endcase
        return m;
    endfunction

    assign load_data  = extract_extend(rd_word, byte_off, size, is_unsigned);
    assign merge_data = merge_store(rd_word, byte_off, size, wdata);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the memory stage and a word-only data memory
// (combinational read gated by write enable, synchronous write).
// Build option: LSU_MISALIGN_CHECK_EN - when defined, misaligned half/word accesses
// complete with rsp_err=1 and no memory access; when undefined they proceed using
// the aligned word (half selects by addr[1], word ignores addr[1:0]).
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready          request handshake; ready only in IDLE
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid/rsp_ready          response handshake; response held until taken
//   rsp_rdata, rsp_err           load result (0 for stores/errors), misalignment flag
//   mem_addr, mem_write_data, mem_write_enable, mem_read_data   data memory interface
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    lsu_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic                  misaligned;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    // Memory is word-only; the address comes straight from the latched request
    // so it is stable (and zero after reset) in every state.
    assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    lsu_lane u_lane (
        .rd_word     (mem_read_data),
        .byte_off    (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            addr_q           <= '0;
            size_q           <= '0;
            we_q             <= 1'b0;
            uns_q            <= 1'b0;
            wdata_q          <= '0;
            rsp_valid        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_rdata        <= '0;
            mem_write_enable <= 1'b0;
            mem_write_data   <= '0;
        end else begin
            case (state)
                // Accept: latch the request and pick the access path.
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        if (misaligned) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_size == SIZE_BYTE || req_size == SIZE_HALF) begin
                            state <= RMW_RD;
                        end else begin
                            mem_write_data   <= req_wdata;
                            mem_write_enable <= 1'b1;
                            state            <= WRITE;
                        end
                    end
                end
                // Load: capture the extended lane data from the ungated read.
                LOAD: begin
                    rsp_rdata <= we_q ? '0 : load_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                // Read half of read-modify-write: capture the merged word.
                RMW_RD: begin
                    mem_write_data   <= merge_data;
                    mem_write_enable <= 1'b1;
                    state            <= WRITE;
                end
                // Write: memory commits on this state's exiting edge.
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    rsp_valid        <= 1'b1;
                    state            <= RESP;
                end
                // Response: hold until the consumer takes it.
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Data memory: write-enable-gated combinational read, synchronous write.
    logic [31:0] mem [0:1023] = '{default: 32'd0};
    assign mem_read_data = mem_write_enable ? 32'd0 : mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_addr[11:2]] <= mem_write_data;

    int we_cnt = 0;
    always @(posedge clk) if (mem_write_enable) we_cnt <= we_cnt + 1;

    // Reference model state
    logic [31:0] ref_mem [0:1023] = '{default: 32'd0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [1:0] off);
`ifdef LSU_MISALIGN_CHECK_EN
        if (sz == 2'b01) return off[0];
        if (sz == 2'b00) return 1'b0;
        return off != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        if (sz == 2'b00) begin
            s = (w >> (8 * off)) & 32'h0000_00FF;
            if (!uns && s[7]) s = s | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            s = (w >> (16 * off[1])) & 32'h0000_FFFF;
            if (!uns && s[15]) s = s | 32'hFFFF_0000;
        end else begin
            s = w;
        end
        return s;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'b00) begin
            sh   = 8 * off;
            mask = 32'h0000_00FF << sh;
            return (w & ~mask) | ((wd & 32'h0000_00FF) << sh);
        end else if (sz == 2'b01) begin
            sh   = 16 * off[1];
            mask = 32'h0000_FFFF << sh;
            return (w & ~mask) | ((wd & 32'h0000_FFFF) << sh);
        end
        return wd;
    endfunction

    task automatic wait_accept(input string tag);
        logic rdy;
        int   n;
        req_valid = 1'b1;
        n = 0;
        do begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        req_valid = 1'b0;
        chk({tag, ".accept"}, {31'd0, rdy}, 32'd1);
    endtask

    task automatic send_req(input string tag, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        wait_accept(tag);
        w     = ref_mem[a[11:2]];
        e.err = ref_misaligned(sz, a[1:0]);
        if (e.err) begin
            e.rdata = 32'd0;
            e.lat   = 1;
        end else if (!we) begin
            e.rdata = ref_load(w, a[1:0], sz, uns);
            e.lat   = 2;
        end else begin
            e.rdata = 32'd0;
            e.lat   = (sz == 2'b00 || sz == 2'b01) ? 3 : 2;
            ref_mem[a[11:2]] = ref_merge(w, a[1:0], sz, wd);
        end
        sb.push_back(e);
    endtask

    task automatic get_rsp(input string tag, input int hold, output logic [31:0] rd);
        exp_t e;
        int   lat;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".sb"}, sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.rdata = 32'd0;
            e.err   = 1'b0;
            e.lat   = 0;
        end
        chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".lat"}, lat, e.lat);
        chk({tag, ".rdata"}, rsp_rdata, e.rdata);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, e.err});
        rd = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata, rd);
            chk({tag, ".hold_rdy"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".released"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          c0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;

        #12;
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);

        // Word store then load
        send_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        get_rsp("sw10", 0, rd);
        chk("sw10.mem", mem[4], 32'hDEADBEEF);
        send_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        get_rsp("lw10", 0, rd);
        chk("lw10.const", rd, 32'hDEADBEEF);

        // Sub-word read-modify-write
        send_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        get_rsp("sw20", 0, rd);
        send_req("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA);
        get_rsp("sb21", 0, rd);
        chk("sb21.mem", mem[8], 32'h1122AA44);
        send_req("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF);
        get_rsp("sh22", 0, rd);
        chk("sh22.mem", mem[8], 32'hBEEFAA44);

        // Load extension
        send_req("sw40", 1'b1, 2'b11, 1'b0, 32'h40, 32'h80FF7F01);
        get_rsp("sw40", 0, rd);
        send_req("lb42", 1'b0, 2'b00, 1'b0, 32'h42, 32'd0);
        get_rsp("lb42", 0, rd);
        chk("lb42.const", rd, 32'hFFFFFFFF);
        send_req("lbu42", 1'b0, 2'b00, 1'b1, 32'h42, 32'd0);
        get_rsp("lbu42", 0, rd);
        chk("lbu42.const", rd, 32'h000000FF);
        send_req("lh42", 1'b0, 2'b01, 1'b0, 32'h42, 32'd0);
        get_rsp("lh42", 0, rd);
        chk("lh42.const", rd, 32'hFFFF80FF);
        send_req("lb40", 1'b0, 2'b00, 1'b0, 32'h40, 32'd0);
        get_rsp("lb40", 0, rd);
        chk("lb40.const", rd, 32'h00000001);
        send_req("lb41", 1'b0, 2'b00, 1'b0, 32'h41, 32'd0);
        get_rsp("lb41", 0, rd);
        send_req("lhu40", 1'b0, 2'b01, 1'b1, 32'h40, 32'd0);
        get_rsp("lhu40", 0, rd);
        send_req("lh41", 1'b0, 2'b01, 1'b0, 32'h41, 32'd0);
        get_rsp("lh41", 0, rd);

        // Misaligned word load
        c0 = we_cnt;
        send_req("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
        get_rsp("lw13", 0, rd);
        chk("lw13.no_write", we_cnt - c0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lw13.const", rd, 32'h00000000);
`else
        chk("lw13.const", rd, 32'hDEADBEEF);
`endif

        // Backpressure, with the next request already presented
        send_req("bp_a", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        req_valid    = 1'b1;
        get_rsp("bp_a", 5, rd);
        chk("bp_a.const", rd, 32'hBEEFAA44);
        chk("bp.idle_ready", {31'd0, req_ready}, 32'd1);
        send_req("bp_b", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        get_rsp("bp_b", 0, rd);

        // Reset in the read phase of a byte store
        send_req("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788);
        get_rsp("sw30", 0, rd);
        c0           = we_cnt;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h31;
        req_wdata    = 32'h000000CC;
        wait_accept("rmw_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("rmw_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rmw_rst.mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rmw_rst.mem_addr", mem_addr, 32'd0);
        chk("rmw_rst.mem_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rmw_rst.no_write", we_cnt - c0, 0);
        chk("rmw_rst.mem", mem[12], 32'h55667788);
        send_req("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        get_rsp("lw30", 0, rd);
        chk("lw30.const", rd, 32'h55667788);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
